// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port byte memory.
// Shares it between fetch and load/store, decodes one MMIO output register and flags bad accesses.
module mem_arbiter #(
  parameter int BUS_WIDTH    = 32,
  parameter int MEM_BYTES    = 64,
  parameter int MMIO_ADDR    = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [BUS_WIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [BUS_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  input  logic [1:0]           d_size,
  input  logic                 d_sz_ex,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic                 d_err,
  output logic [BUS_WIDTH-1:0] m_address,
  output logic [BUS_WIDTH-1:0] m_data_in,
  output logic                 m_wr_en,
  output logic [1:0]           m_mem_size,
  output logic                 m_sz_ex,
  input  logic [BUS_WIDTH-1:0] m_rdata,
  output logic [BUS_WIDTH-1:0] mmio_out,
  output logic                 mmio_wr
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]        LIMIT     = CW'(STARVE_LIMIT);
  localparam logic [BUS_WIDTH:0]   MEM_LIMIT = (BUS_WIDTH + 1)'(MEM_BYTES);
  localparam logic [BUS_WIDTH-1:0] MMIO_A    = BUS_WIDTH'(MMIO_ADDR);
  localparam logic [1:0]           SZ_WORD   = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {T_MEM, T_MMIO, T_ERR} tgt_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        starve_q, starve_d;
  logic                 sel_data_q, sel_data_d;
  logic                 we_q, we_d;
  logic [BUS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]           size_q, size_d;
  logic                 sz_ex_q, sz_ex_d;
  logic [BUS_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [BUS_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                 err_q, err_d;
  logic [BUS_WIDTH-1:0] mmio_out_q, mmio_out_d;
  logic                 mmio_wr_q, mmio_wr_d;

  logic [1:0]           nb_m1;
  logic [BUS_WIDTH:0]   last_byte;
  tgt_t                 tgt;
  logic                 fetch_wins;
  logic [BUS_WIDTH-1:0] resp_data;

  // Extra top bit keeps addr + nbytes - 1 from wrapping near the top of the address space.
  always_comb begin
    case (size_q)
      2'b00:   nb_m1 = 2'd0;
      2'b01:   nb_m1 = 2'd1;
      default: nb_m1 = 2'd3;
    endcase
    last_byte = {1'b0, addr_q} + {{(BUS_WIDTH-1){1'b0}}, nb_m1};
    tgt = T_ERR;
    if (size_q != 2'b11) begin
      if (last_byte < MEM_LIMIT) tgt = T_MEM;
      else if (sel_data_q && addr_q == MMIO_A && size_q == SZ_WORD) tgt = T_MMIO;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    sel_data_d = sel_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sz_ex_d    = sz_ex_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
    mmio_out_d = mmio_out_q;
    mmio_wr_d  = 1'b0;
    resp_data  = '0;
    fetch_wins = if_req && (!d_req || starve_q == LIMIT);

    if (state_q == S_ACCESS) begin
      state_d = S_RESP;
      err_d   = (tgt == T_ERR);
      if (tgt == T_MEM && !(sel_data_q && we_q)) resp_data = m_rdata;
      else if (tgt == T_MMIO && !we_q) resp_data = mmio_out_q;
      if (sel_data_q) d_rdata_d = resp_data;
      else if_rdata_d = resp_data;
      if (tgt == T_MMIO && we_q) begin
        mmio_out_d = wdata_q;
        mmio_wr_d  = 1'b1;
      end
    end else if (d_req && !fetch_wins) begin
      state_d    = S_ACCESS;
      sel_data_d = 1'b1;
      we_d       = d_we;
      addr_d     = d_addr;
      wdata_d    = d_wdata;
      size_d     = d_size;
      sz_ex_d    = d_sz_ex;
      if (!if_req) starve_d = '0;
      else if (starve_q != LIMIT) starve_d = starve_q + CW'(1);
    end else if (if_req) begin
      state_d    = S_ACCESS;
      sel_data_d = 1'b0;
      we_d       = 1'b0;
      addr_d     = if_addr;
      wdata_d    = '0;
      size_d     = SZ_WORD;
      sz_ex_d    = 1'b0;
      starve_d   = '0;
    end else begin
      state_d  = S_IDLE;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      sel_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_WORD;
      sz_ex_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
      mmio_out_q <= '0;
      mmio_wr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      sel_data_q <= sel_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      sz_ex_q    <= sz_ex_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
      mmio_out_q <= mmio_out_d;
      mmio_wr_q  <= mmio_wr_d;
    end
  end

  // Port is parked outside ACCESS; the write strobe is also killed by a reset edge.
  always_comb begin
    m_address  = '0;
    m_data_in  = '0;
    m_wr_en    = 1'b0;
    m_mem_size = SZ_WORD;
    m_sz_ex    = 1'b0;
    if (state_q == S_ACCESS) begin
      m_address  = addr_q;
      m_data_in  = wdata_q;
      m_wr_en    = sel_data_q && we_q && (tgt == T_MEM) && !rst;
      m_mem_size = size_q;
      m_sz_ex    = sz_ex_q;
    end
  end

  assign if_gnt    = (state_q == S_ACCESS) && !sel_data_q;
  assign d_gnt     = (state_q == S_ACCESS) && sel_data_q;
  assign if_rvalid = (state_q == S_RESP) && !sel_data_q;
  assign d_rvalid  = (state_q == S_RESP) && sel_data_q;
  assign if_err    = if_rvalid && err_q;
  assign d_err     = d_rvalid && err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mmio_out  = mmio_out_q;
  assign mmio_wr   = mmio_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked every cycle
// against a transaction-level model of arbitration, memory and the MMIO register.
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_sz_ex, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] m_address, m_data_in, m_rdata, mmio_out;
  logic        m_wr_en, m_sz_ex, mmio_wr;
  logic [1:0]  m_mem_size;

  always #5 clk = ~clk;

  mem_arbiter #(.BUS_WIDTH(32), .MEM_BYTES(64), .MMIO_ADDR(256), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_sz_ex(d_sz_ex), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_address(m_address), .m_data_in(m_data_in), .m_wr_en(m_wr_en), .m_mem_size(m_mem_size),
    .m_sz_ex(m_sz_ex), .m_rdata(m_rdata), .mmio_out(mmio_out), .mmio_wr(mmio_wr)
  );

  logic [7:0] env_mem [64];
  logic [7:0] ref_mem [64];
  int total = 0, bad = 0;
  int wr_cnt = 0, mmio_wr_cnt = 0, d_rv_cnt = 0;
  byte gq[$];

  // reference model state
  int          phase, cnt;
  logic        t_d, t_we, t_ex;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  t_size;
  logic [31:0] r_mmio;
  logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_chkdata, e_wr, e_mmio_wr;
  logic [31:0] e_data, e_addr;
  logic [1:0]  e_size;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] rd_bytes(input logic [7:0] m [64], input logic [31:0] a,
                                           input logic [1:0] sz, input logic ex);
    logic [31:0] v;
    int nb;
    v = 0;
    nb = nbytes(sz);
    for (int i = 0; i < nb; i++)
      if (longint'(a) + i < 64) v[8*i +: 8] = m[a + i];
    if (ex && nb < 4)
      for (int i = 8 * nb; i < 32; i++) v[i] = v[8*nb-1];
    return v;
  endfunction

  // 0 = memory, 1 = MMIO register, 2 = error
  function automatic int classify(input logic is_d, input logic [31:0] a, input logic [1:0] sz);
    longint last;
    if (sz == 2'b11) return 2;
    last = longint'(a) + nbytes(sz) - 1;
    if (last < 64) return 0;
    if (is_d && a == 32'd256 && sz == 2'b10) return 1;
    return 2;
  endfunction

  always_comb m_rdata = rd_bytes(env_mem, m_address, m_mem_size, m_sz_ex);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predicts what the next clock edge does, from the inputs currently applied.
  task automatic model_edge();
    int tg;
    logic fw;
    {e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_chkdata, e_wr, e_mmio_wr} = '0;
    e_data = 0; e_addr = 0; e_size = 2'b10;
    if (rst) begin
      phase = 0; cnt = 0; r_mmio = 0;
    end else if (phase == 1) begin
      tg = classify(t_d, t_addr, t_size);
      e_err = (tg == 2);
      e_chkdata = !(t_d && t_we);
      if (tg == 0) begin
        if (t_d && t_we) begin
          for (int i = 0; i < nbytes(t_size); i++) ref_mem[t_addr + i] = t_wdata[8*i +: 8];
        end else e_data = rd_bytes(ref_mem, t_addr, t_size, t_ex);
      end else if (tg == 1) begin
        if (t_we) begin r_mmio = t_wdata; e_mmio_wr = 1; end
        else e_data = r_mmio;
      end
      if (t_d) e_d_rv = 1; else e_if_rv = 1;
      phase = 2;
    end else begin
      fw = if_req && (!d_req || cnt == LIM);
      if (d_req && !fw) begin
        t_d = 1; t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_size = d_size; t_ex = d_sz_ex;
        cnt = if_req ? ((cnt < LIM) ? cnt + 1 : cnt) : 0;
      end else if (if_req) begin
        t_d = 0; t_we = 0; t_addr = if_addr; t_wdata = 0; t_size = 2'b10; t_ex = 0;
        cnt = 0;
      end else begin
        cnt = 0;
        phase = 0;
        return;
      end
      if (t_d) e_d_gnt = 1; else e_if_gnt = 1;
      e_addr = t_addr; e_size = t_size;
      e_wr = t_d && t_we && (classify(t_d, t_addr, t_size) == 0);
      phase = 1;
    end
  endtask

  task automatic check_outputs();
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("if_rvalid", if_rvalid, e_if_rv);
    chk("d_rvalid", d_rvalid, e_d_rv);
    if (e_if_rv) begin
      chk("if_rdata", if_rdata, e_data);
      chk("if_err", if_err, e_err);
    end
    if (e_d_rv) begin
      if (e_chkdata) chk("d_rdata", d_rdata, e_data);
      chk("d_err", d_err, e_err);
    end
    chk("m_wr_en", m_wr_en, e_wr);
    chk("mmio_wr", mmio_wr, e_mmio_wr);
    chk("mmio_out", mmio_out, r_mmio);
    chk("m_address", m_address, e_addr);
    chk("m_mem_size", 32'(m_mem_size), 32'(e_size));
    if (m_wr_en) wr_cnt++;
    if (mmio_wr) mmio_wr_cnt++;
    if (d_rvalid) d_rv_cnt++;
    if (d_gnt) gq.push_back(8'd68);
    if (if_gnt) gq.push_back(8'd73);
  endtask

  // Inputs are applied just after a falling edge; the attached memory commits on the rising edge.
  task automatic cycle();
    logic        wr;
    logic [31:0] wa, wd;
    logic [1:0]  ws;
    #1;
    wr = m_wr_en; wa = m_address; wd = m_data_in; ws = m_mem_size;
    model_edge();
    @(posedge clk);
    if (wr)
      for (int i = 0; i < nbytes(ws); i++)
        if (longint'(wa) + i < 64) env_mem[wa + i] = wd[8*i +: 8];
    @(negedge clk);
    check_outputs();
  endtask

  task automatic d_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic ex,
                      output logic [31:0] rdata, output logic err);
    int n;
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_size = sz; d_sz_ex = ex;
    n = 0;
    do begin cycle(); n++; end while (!d_gnt && n < 20);
    chk("d_gnt_seen", d_gnt, 1);
    d_req = 0;
    n = 0;
    do begin cycle(); n++; end while (!d_rvalid && n < 20);
    chk("d_rvalid_seen", d_rvalid, 1);
    rdata = d_rdata; err = d_err;
  endtask

  task automatic rand_d();
    int r;
    r = $urandom_range(0, 9);
    d_addr = (r <= 5) ? $urandom_range(0, 63) : (r == 6) ? 32'd256 :
             (r == 7) ? $urandom_range(60, 70) : (r == 8) ? 32'd257 : $urandom;
    d_size = (r == 6 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
    d_we = 1'($urandom_range(0, 1));
    d_wdata = $urandom;
    d_sz_ex = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w0, n;
    string       pat;
    pat = "DDDDIDDDDI";
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    for (int i = 16; i < 24; i++) begin env_mem[i] = 0; ref_mem[i] = 0; end
    {env_mem[3], env_mem[2], env_mem[1], env_mem[0]} = 32'h00110113;
    {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h00110113;
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_size = 0; d_sz_ex = 0;
    phase = 0; cnt = 0; r_mmio = 0;
    cycle(); cycle();
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mmio_out", mmio_out, 0);
    rst = 0;

    // fetch of word 0
    if_req = 1; if_addr = 0;
    cycle();
    chk("fetch_gnt_cycle1", if_gnt, 1);
    if_req = 0;
    cycle();
    chk("fetch_rvalid_cycle2", if_rvalid, 1);
    chk("fetch_word0", if_rdata, 32'h00110113);

    // store word then signed half load
    w0 = wr_cnt;
    d_op(1, 16, 32'hDEADBEEF, 2'b10, 0, rd, er);
    chk("store_wr_pulses", wr_cnt - w0, 1);
    d_op(0, 18, 0, 2'b01, 1, rd, er);
    chk("load_half_sext", rd, 32'hFFFFDEAD);

    // MMIO store
    w0 = wr_cnt; n = mmio_wr_cnt;
    d_op(1, 256, 32'h5, 2'b10, 0, rd, er);
    chk("mmio_out_val", mmio_out, 32'h5);
    chk("mmio_wr_pulses", mmio_wr_cnt - n, 1);
    chk("mmio_no_mem_wr", wr_cnt - w0, 0);

    // error accesses
    w0 = wr_cnt;
    d_op(0, 62, 0, 2'b10, 0, rd, er);
    chk("err_oob_flag", er, 1);
    chk("err_oob_data", rd, 0);
    d_op(0, 0, 0, 2'b11, 0, rd, er);
    chk("err_size_flag", er, 1);
    chk("err_size_data", rd, 0);
    d_op(1, 61, 32'h12345678, 2'b10, 0, rd, er);
    chk("err_store_flag", er, 1);
    chk("err_no_wr", wr_cnt - w0, 0);

    // both requesters held continuously
    gq.delete();
    d_req = 1; d_we = 0; d_addr = 4; d_size = 2'b10; d_sz_ex = 0;
    if_req = 1; if_addr = 8;
    n = 0;
    while (gq.size() < 10 && n < 60) begin cycle(); n++; end
    d_req = 0; if_req = 0;
    chk("starve_grants", gq.size(), 10);
    for (int i = 0; i < 10 && i < gq.size(); i++) chk("starve_order", 32'(gq[i]), 32'(pat[i]));
    cycle(); cycle(); cycle();

    // reset during ACCESS of a store
    n = d_rv_cnt;
    d_req = 1; d_we = 1; d_addr = 20; d_wdata = 32'hA5A5A5A5; d_size = 2'b10;
    w0 = 0;
    do begin cycle(); w0++; end while (!d_gnt && w0 < 20);
    chk("abort_gnt_seen", d_gnt, 1);
    d_req = 0; rst = 1;
    cycle();
    rst = 0;
    cycle(); cycle(); cycle();
    chk("abort_no_rvalid", d_rv_cnt - n, 0);
    chk("abort_mem20", {env_mem[23], env_mem[22], env_mem[21], env_mem[20]}, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (d_req && d_gnt) d_req = 0;
      if (!d_req && $urandom_range(0, 2) == 0) begin rand_d(); d_req = 1; end
      if (if_req && if_gnt) if_req = 0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_addr = ($urandom_range(0, 15) == 0) ? 32'd256 : $urandom_range(0, 68);
        if_req = 1;
      end
      cycle();
    end
    if (d_req && d_gnt) d_req = 0;
    if (if_req && if_gnt) if_req = 0;
    n = 0;
    while ((d_req || if_req) && n < 40) begin
      cycle(); n++;
      if (d_req && d_gnt) d_req = 0;
      if (if_req && if_gnt) if_req = 0;
    end
    d_req = 0; if_req = 0;
    cycle(); cycle(); cycle();
    for (int i = 0; i < 64; i++) chk("final_mem", 32'(env_mem[i]), 32'(ref_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
